// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared types and default constants for the clock monitor.
// Defaults match the 48 MHz reference / 1.5 MHz audio clock pairing:
// 1024 reference cycles per window, 32 expected edges, +/-2 tolerance,
// 256 edge-free cycles before loss is declared.
// -----------------------------------------------------------------------------
package clk_mon_pkg;

  localparam int unsigned DEF_WINDOW      = 1024;
  localparam int unsigned DEF_EXP_COUNT   = 32;
  localparam int unsigned DEF_TOL         = 2;
  localparam int unsigned DEF_LOSS_CYCLES = 256;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  // Lower tolerance bound, clamped at zero when the tolerance exceeds the target
  function automatic int unsigned tol_lo(input int unsigned exp_cnt,
                                         input int unsigned tol);
    return (tol > exp_cnt) ? 32'd0 : (exp_cnt - tol);
  endfunction

endpackage

// File: rtl/clk_monitor_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer followed by a registered rising-edge detector for one
// asynchronous input. A rising transition on i_async shows up as a one-cycle
// o_edge pulse three i_clk cycles later. Reusable for any slow async input.
//
// Ports:
//   i_clk    in   sampling clock
//   i_rst    in   asynchronous active-high reset
//   i_async  in   asynchronous input
//   o_edge   out  one-cycle rising-edge pulse (registered)
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_edge;

  // Synchronizer chain plus delayed copy for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_edge   <= r_sync & ~r_sync_d;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
// Frequency and loss-of-clock monitor. Samples a slow monitored clock on the
// reference clock, counts its rising edges per WINDOW reference cycles and
// reports the count plus an in-tolerance flag. After enable, one full window
// is discarded (SETTLE) before back-to-back MEASURE windows are reported.
//
// Optional feature (macro CLK_MON_LOSS_DETECT_EN):
//   defined   - gap counter built; o_lost is a sticky loss-of-clock flag that
//               also forces o_ok low.
//   undefined - no gap counter; o_lost is tied low.
//
// Parameters:
//   WINDOW       reference cycles per window (power of two, >= 16)
//   EXP_COUNT    expected edges per window
//   TOL          allowed deviation from EXP_COUNT
//   LOSS_CYCLES  edge-free cycles before loss is declared
//   CNT_W        width of the edge count
//
// Ports:
//   i_clk    in   reference clock
//   i_rst    in   asynchronous active-high reset
//   i_mon    in   monitored clock (asynchronous, < i_clk/4)
//   i_en     in   monitor enable
//   o_count  out  edge count of the last completed window
//   o_valid  out  one-cycle pulse when o_count updates
//   o_ok     out  last window within EXP_COUNT +/- TOL (and no loss)
//   o_lost   out  sticky loss-of-clock flag
// -----------------------------------------------------------------------------
module clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned WINDOW      = DEF_WINDOW,
  parameter int unsigned EXP_COUNT   = DEF_EXP_COUNT,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned LOSS_CYCLES = DEF_LOSS_CYCLES,
  parameter int unsigned CNT_W       = $clog2(WINDOW + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mon,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output logic             o_ok,
  output logic             o_lost
);

  localparam int unsigned       WIN_W    = $clog2(WINDOW);
  localparam int unsigned       TOL_LO   = tol_lo(EXP_COUNT, TOL);
  localparam int unsigned       TOL_HI   = EXP_COUNT + TOL;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t           r_state;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_edges;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_ok;

  logic             w_edge;
  logic             w_win_end;
  logic [CNT_W-1:0] w_edges_inc;
  logic             w_in_tol;
  logic             w_lost;

  // Synchronize the monitored clock and extract its rising edges
  sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_mon),
    .o_edge  (w_edge)
  );

  assign w_win_end = (r_win == WIN_LAST);

  // Edge count including this cycle's edge, saturating
  always_comb begin
    w_edges_inc = r_edges;
    if (w_edge && (r_edges != CNT_MAX)) begin
      w_edges_inc = r_edges + CNT_W'(1);
    end
  end

  assign w_in_tol = (32'(w_edges_inc) >= TOL_LO) && (32'(w_edges_inc) <= TOL_HI);

`ifdef CLK_MON_LOSS_DETECT_EN
  localparam int unsigned      GAP_W   = $clog2(LOSS_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(LOSS_CYCLES);

  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_nxt;
  logic             r_lost;
  logic             w_active;
  logic             w_lost_set;

  assign w_active = (r_state != ST_IDLE);

  // Gap counts cycles elapsed since the last edge cycle (that cycle counts as
  // one), so loss asserts exactly LOSS_CYCLES cycles after the last edge.
  always_comb begin
    w_gap_nxt = r_gap;
    if (w_edge) begin
      w_gap_nxt = GAP_W'(1);
    end else if (r_gap != GAP_LIM) begin
      w_gap_nxt = r_gap + GAP_W'(1);
    end
  end

  assign w_lost_set = w_active && (w_gap_nxt == GAP_LIM);

  // Sticky loss flag; only a disable or reset clears it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gap  <= '0;
      r_lost <= 1'b0;
    end else if (!i_en || !w_active) begin
      r_gap  <= '0;
      r_lost <= 1'b0;
    end else begin
      r_gap <= w_gap_nxt;
      if (w_lost_set) begin
        r_lost <= 1'b1;
      end
    end
  end

  assign w_lost = i_en & (r_lost | w_lost_set);
  assign o_lost = r_lost;
`else
  assign w_lost = 1'b0;
  assign o_lost = 1'b0;
`endif

  // Monitor FSM: window sequencing, edge counting and registered reporting
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_edges <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!i_en) begin
        // Disable wins over everything, including a window end; o_count holds
        r_state <= ST_IDLE;
        r_win   <= '0;
        r_edges <= '0;
        r_ok    <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state <= ST_SETTLE;
            r_win   <= '0;
            r_edges <= '0;
          end
          ST_SETTLE: begin
            // Settle window result is never reported
            r_win   <= r_win + WIN_W'(1);
            r_edges <= '0;
            if (w_win_end) begin
              r_state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            r_win <= r_win + WIN_W'(1);
            if (w_win_end) begin
              r_count <= w_edges_inc;
              r_valid <= 1'b1;
              r_ok    <= w_in_tol;
              r_edges <= '0;
            end else begin
              r_edges <= w_edges_inc;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_win   <= '0;
            r_edges <= '0;
          end
        endcase
        // A lost clock overrides any window verdict
        if (w_lost) begin
          r_ok <= 1'b0;
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_ok    = r_ok;

endmodule

// File: tb/tb_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_monitor
// Self-checking bench for clk_monitor with default parameters. A behavioural
// model records the cycle in which every monitored rising edge becomes visible
// and derives window counts, report timing, tolerance and loss from those
// timestamps. Loss expectations follow CLK_MON_LOSS_DETECT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_monitor;

  localparam int W    = 1024;
  localparam int EXPC = 32;
  localparam int TOLV = 2;
  localparam int LOSS = 256;
  localparam int CW   = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mon = 1'b0;
  logic          en  = 1'b0;
  logic [CW-1:0] count;
  logic          valid;
  logic          ok;
  logic          lost;

  int cyc        = 0;
  int edge_q[$];
  int last_edge  = -100000;
  int mon_period = 0;
  int cur_p      = 0;
  int ph         = 0;
  int en_cycle   = 0;
  int last_rep   = 0;
  int last_count = 0;
  bit last_ok    = 1'b0;
  int n_tests    = 0;
  int n_fail     = 0;

  clk_monitor #(
    .WINDOW      (W),
    .EXP_COUNT   (EXPC),
    .TOL         (TOLV),
    .LOSS_CYCLES (LOSS),
    .CNT_W       (CW)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_mon   (mon),
    .i_en    (en),
    .o_count (count),
    .o_valid (valid),
    .o_ok    (ok),
    .o_lost  (lost)
  );

  always #5 clk = ~clk;

  // During cycle n (between posedge n and n+1) cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  // Monitored clock: 50% duty, period changes take effect at a period boundary.
  // A rise driven in cycle n becomes a visible edge in cycle n+3.
  always @(negedge clk) begin : mon_gen
    logic prev;
    prev = mon;
    if (ph == 0) cur_p = mon_period;
    if (cur_p == 0) begin
      mon = 1'b0;
    end else begin
      mon = (ph < cur_p / 2);
      ph  = (ph + 1 >= cur_p) ? 0 : ph + 1;
    end
    if (mon && !prev) begin
      edge_q.push_back(cyc + 3);
      last_edge = cyc + 3;
    end
  end

  function automatic int model_count(input int a, input int b);
    int n = 0;
    foreach (edge_q[i]) if (edge_q[i] >= a && edge_q[i] < b) n++;
    return n;
  endfunction

  function automatic bit model_in_tol(input int n);
    int lo = (EXPC > TOLV) ? EXPC - TOLV : 0;
    return (n >= lo) && (n <= EXPC + TOLV);
  endfunction

  // Reports appear in cycle en_cycle + 1 + k*W for k >= 2
  function automatic int next_report(input int after);
    int k = (after - (en_cycle + 1)) / W + 1;
    if (k < 2) k = 2;
    return en_cycle + 1 + k * W;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mon_period = 32;
    repeat (3) tick();
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b want 0", ok); end
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL reset_lost: got %b want 0", lost); end
    rst = 1'b0;
    repeat (300) tick();
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", valid); end
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL idle_lost: got %b want 0", lost); end
  endtask

  task automatic test_nominal();
    int rep, exp_n;
    bit exp_ok;
    mon_period = 32;
    repeat ($urandom_range(5, 40)) tick();
    en = 1'b1; en_cycle = cyc;
    for (int k = 1; k <= 3; k++) begin
      rep = en_cycle + 1 + (k + 1) * W;
      wait_until(rep - 1);
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL nominal_early_valid k=%0d: got %b want 0", k, valid); end
      tick();
      exp_n = model_count(rep - W, rep); exp_ok = model_in_tol(exp_n);
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL nominal_valid k=%0d: got %b want 1", k, valid); end
      n_tests++; if (count !== CW'(exp_n)) begin n_fail++; $display("FAIL nominal_count k=%0d: got %0d want %0d", k, count, exp_n); end
      n_tests++; if (ok !== exp_ok) begin n_fail++; $display("FAIL nominal_ok k=%0d: got %b want %b", k, ok, exp_ok); end
      n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL nominal_lost k=%0d: got %b want 0", k, lost); end
      last_count = exp_n; last_rep = rep; last_ok = exp_ok;
      tick();
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL nominal_pulse_width k=%0d: got %b want 0", k, valid); end
    end
  endtask

  task automatic test_periods();
    int p, rep, exp_n;
    bit exp_ok;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) p = 30;
      else if (i == 1) p = 28;
      else p = 2 * int'($urandom_range(12, 20));
      mon_period = p;
      repeat ($urandom_range(1, 200)) tick();
      for (int j = 0; j < 2; j++) begin
        rep = next_report(cyc);
        wait_until(rep);
        exp_n = model_count(rep - W, rep); exp_ok = model_in_tol(exp_n);
        n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL period_valid p=%0d: got %b want 1", p, valid); end
        n_tests++; if (count !== CW'(exp_n)) begin n_fail++; $display("FAIL period_count p=%0d: got %0d want %0d", p, count, exp_n); end
        n_tests++; if (ok !== exp_ok) begin n_fail++; $display("FAIL period_ok p=%0d n=%0d: got %b want %b", p, exp_n, ok, exp_ok); end
        last_count = exp_n; last_rep = rep; last_ok = exp_ok;
      end
    end
  endtask

  task automatic test_disable();
    int rep, exp_n;
    bit exp_ok;
    mon_period = 32;
    wait_until(last_rep + int'($urandom_range(10, 500)));
    en = 1'b0;
    tick();
    n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL disable_ok: got %b want 0", ok); end
    n_tests++; if (count !== CW'(last_count)) begin n_fail++; $display("FAIL disable_count_hold: got %0d want %0d", count, last_count); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL disable_valid: got %b want 0", valid); end
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL disable_lost: got %b want 0", lost); end
    repeat ($urandom_range(5, 50)) tick();
    en = 1'b1; en_cycle = cyc;
    rep = en_cycle + 1 + W;
    wait_until(rep);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL settle_discard_valid: got %b want 0", valid); end
    rep = rep + W;
    wait_until(rep);
    exp_n = model_count(rep - W, rep); exp_ok = model_in_tol(exp_n);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL reenable_valid: got %b want 1", valid); end
    n_tests++; if (count !== CW'(exp_n)) begin n_fail++; $display("FAIL reenable_count: got %0d want %0d", count, exp_n); end
    n_tests++; if (ok !== exp_ok) begin n_fail++; $display("FAIL reenable_ok: got %b want %b", ok, exp_ok); end
    last_count = exp_n; last_rep = rep; last_ok = exp_ok;
  endtask

  task automatic test_loss();
    int t, rep, exp_n;
    bit exp_ok;
    mon_period = 0;
    repeat (100) tick();
    t = last_edge;
    wait_until(t + LOSS - 1);
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL loss_early: got %b want 0", lost); end
    n_tests++; if (ok !== last_ok) begin n_fail++; $display("FAIL loss_early_ok: got %b want %b", ok, last_ok); end
    tick();
`ifdef CLK_MON_LOSS_DETECT_EN
    n_tests++; if (lost !== 1'b1) begin n_fail++; $display("FAIL loss_set: got %b want 1", lost); end
    n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL loss_ok_clear: got %b want 0", ok); end
    mon_period = 32;
    for (int j = 0; j < 2; j++) begin
      rep = next_report(cyc);
      wait_until(rep);
      exp_n = model_count(rep - W, rep);
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL lost_report_valid: got %b want 1", valid); end
      n_tests++; if (count !== CW'(exp_n)) begin n_fail++; $display("FAIL lost_report_count: got %0d want %0d", count, exp_n); end
      n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL lost_report_ok: got %b want 0", ok); end
      n_tests++; if (lost !== 1'b1) begin n_fail++; $display("FAIL lost_sticky: got %b want 1", lost); end
    end
`else
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL noloss_lost: got %b want 0", lost); end
    n_tests++; if (ok !== last_ok) begin n_fail++; $display("FAIL noloss_ok: got %b want %b", ok, last_ok); end
    rep = next_report(t + W);
    wait_until(rep);
    exp_n = model_count(rep - W, rep); exp_ok = model_in_tol(exp_n);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL stopped_valid: got %b want 1", valid); end
    n_tests++; if (count !== CW'(exp_n)) begin n_fail++; $display("FAIL stopped_count: got %0d want %0d", count, exp_n); end
    n_tests++; if (ok !== exp_ok) begin n_fail++; $display("FAIL stopped_ok: got %b want %b", ok, exp_ok); end
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL stopped_lost: got %b want 0", lost); end
    mon_period = 32;
`endif
    en = 1'b0;
    tick();
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL loss_cleared: got %b want 0", lost); end
    n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL loss_disable_ok: got %b want 0", ok); end
    repeat (10) tick();
    en = 1'b1; en_cycle = cyc;
  endtask

  task automatic test_reset_mid();
    int rep, exp_n;
    bit exp_ok;
    rep = en_cycle + 1 + 2 * W;
    wait_until(rep);
    exp_n = model_count(rep - W, rep); exp_ok = model_in_tol(exp_n);
    n_tests++; if (count !== CW'(exp_n)) begin n_fail++; $display("FAIL premid_count: got %0d want %0d", count, exp_n); end
    n_tests++; if (ok !== exp_ok) begin n_fail++; $display("FAIL premid_ok: got %b want %b", ok, exp_ok); end
    wait_until(rep + W / 2);
    #2; rst = 1'b1; #1;
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL async_rst_count: got %0d want 0", count); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", valid); end
    n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL async_rst_ok: got %b want 0", ok); end
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL async_rst_lost: got %b want 0", lost); end
    repeat (3) tick();
    rst = 1'b0; en_cycle = cyc;
    rep = en_cycle + 1 + 2 * W;
    wait_until(rep - 1);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL postrst_early_valid: got %b want 0", valid); end
    tick();
    exp_n = model_count(rep - W, rep); exp_ok = model_in_tol(exp_n);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL postrst_valid: got %b want 1", valid); end
    n_tests++; if (count !== CW'(exp_n)) begin n_fail++; $display("FAIL postrst_count: got %0d want %0d", count, exp_n); end
    n_tests++; if (ok !== exp_ok) begin n_fail++; $display("FAIL postrst_ok: got %b want %b", ok, exp_ok); end
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_periods();
    test_disable();
    test_loss();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
